// File: rtl/kypd_tone_pkg.sv
// Shared types and constants for the keypad tone player.
// Latency: n/a (package only).
// Backpressure: n/a.
package kypd_tone_pkg;

  localparam int CNT_W = 18;
  localparam int KEY_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Half periods at 100 MHz. Slot 0 is C5 so that a key code's low 3 bits
  // are directly the note index (keys 1..7 -> 1..7, key 8 -> 0).
  localparam logic [CNT_W-1:0] HALF_C5 = 18'd95557;
  localparam logic [CNT_W-1:0] HALF_C4 = 18'd191110;
  localparam logic [CNT_W-1:0] HALF_D4 = 18'd170265;
  localparam logic [CNT_W-1:0] HALF_E4 = 18'd151685;
  localparam logic [CNT_W-1:0] HALF_F4 = 18'd143172;
  localparam logic [CNT_W-1:0] HALF_G4 = 18'd127551;
  localparam logic [CNT_W-1:0] HALF_A4 = 18'd113636;
  localparam logic [CNT_W-1:0] HALF_B4 = 18'd101239;

  typedef struct packed {
    logic       is_note;
    logic [2:0] idx;
  } note_t;

  // Keys 1..8 are notes; 0, 9 and A..F are rests.
  function automatic note_t map_code(input logic [KEY_W-1:0] code);
    note_t n;
    n.is_note = (code >= 4'd1) && (code <= 4'd8);
    n.idx     = code[2:0];
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] half_of(input logic [2:0] idx);
    logic [CNT_W-1:0] h;
    case (idx)
      3'd1:    h = HALF_C4;
      3'd2:    h = HALF_D4;
      3'd3:    h = HALF_E4;
      3'd4:    h = HALF_F4;
      3'd5:    h = HALF_G4;
      3'd6:    h = HALF_A4;
      3'd7:    h = HALF_B4;
      default: h = HALF_C5;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/kypd_tone_player_debounce.sv
// Debounces the decoder key code and pulses key_event when the stable code changes.
// Latency: event is high DEBOUNCE_CYC cycles after the first cycle the candidate is held.
// Backpressure: none; the decoder holds its code, so a repeated key gives no event.
module kypd_debounce
  import kypd_tone_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_code_i,
  output logic             key_event_o,
  output logic [KEY_W-1:0] stable_code_o
);

  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic [KEY_W-1:0] cand_q;
  logic [KEY_W-1:0] stable_code_q;
  logic [KEY_W-1:0] last_code_q;
  logic [DB_W-1:0]  cnt_q;

  // Track the candidate; restart the count on any change, accept once it has aged out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q        <= '0;
      cnt_q         <= '0;
      stable_code_q <= '0;
    end else if (key_code_i != cand_q) begin
      cand_q <= key_code_i;
      cnt_q  <= '0;
    end else if (cnt_q == DB_LAST) begin
      stable_code_q <= cand_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // last_code trails stable_code by one cycle, so a change shows as a 1-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_code_q <= '0;
    end else begin
      last_code_q <= stable_code_q;
    end
  end

  assign key_event_o   = (stable_code_q != last_code_q);
  assign stable_code_o = stable_code_q;

endmodule

// File: rtl/kypd_tone_player.sv
// Keypad tone player: debounced key -> note FSM (IDLE/PLAY/GAP) -> square-wave speaker.
// Latency: playing/spk rise one clock after the debounce event; all outputs registered.
// Backpressure: none; one pending note is held during GAP. KYPD_TONE_VOLUME_EN adds vol PWM.
module kypd_tone_player
  import kypd_tone_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int NOTE_CYC     = 25_000_000,
  parameter int GAP_CYC      = 5_000_000,
  parameter int TONE_SHIFT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_code,
`ifdef KYPD_TONE_VOLUME_EN
  input  logic [1:0]       vol,
`endif
  output logic             spk,
  output logic             playing,
  output logic [2:0]       note_idx
);

  localparam int MAX_CYC = (NOTE_CYC > GAP_CYC) ? NOTE_CYC : GAP_CYC;
  localparam int DUR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_CYC - 1);
  localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'(GAP_CYC - 1);

  logic             key_event;
  logic [KEY_W-1:0] stable_code;
  note_t            ev_note;
  logic             ev_is_note;
  logic             vol_gate;

  state_e           state_q;
  logic [DUR_W-1:0] dur_q;
  logic [CNT_W-1:0] half_q;
  logic             tone_q;
  logic [2:0]       note_q;
  logic             pend_vld_q;
  logic [2:0]       pend_note_q;

  logic             go_play;
  logic [2:0]       play_idx;

  kypd_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_code_i   (key_code),
    .key_event_o  (key_event),
    .stable_code_o(stable_code)
  );

  assign ev_note    = map_code(stable_code);
  assign ev_is_note = key_event & ev_note.is_note;

  // Reload value for the half-period counter; the toggle happens when it hits 0.
  function automatic logic [CNT_W-1:0] half_reload(input logic [2:0] idx);
    return (half_of(idx) >> TONE_SHIFT) - CNT_W'(1);
  endfunction

`ifdef KYPD_TONE_VOLUME_EN
  logic [1:0] pwm_cnt_q;
  logic [1:0] pwm_cnt_d;

  assign pwm_cnt_d = pwm_cnt_q + 2'd1;
  // spk is registered, so gate it with the PWM phase that is current when it is visible.
  assign vol_gate  = (pwm_cnt_d <= vol);

  // Free-running PWM phase for the volume duty cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`else
  assign vol_gate = 1'b1;
`endif

  // Decide whether PLAY (re)starts this cycle and with which note; a fresh note
  // event beats the pending one at the end of GAP.
  always_comb begin
    go_play  = 1'b0;
    play_idx = ev_note.idx;
    case (state_q)
      IDLE, PLAY: go_play = ev_is_note;
      GAP: begin
        if (dur_q == '0) begin
          if (ev_is_note) begin
            go_play = 1'b1;
          end else if (!key_event && pend_vld_q) begin
            go_play  = 1'b1;
            play_idx = pend_note_q;
          end
        end
      end
      default: go_play = 1'b0;
    endcase
  end

  // Note FSM with tone generator, shared duration/gap counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dur_q       <= '0;
      half_q      <= '0;
      tone_q      <= 1'b0;
      note_q      <= '0;
      pend_vld_q  <= 1'b0;
      pend_note_q <= '0;
      spk         <= 1'b0;
      playing     <= 1'b0;
      note_idx    <= '0;
    end else if (go_play) begin
      state_q    <= PLAY;
      note_q     <= play_idx;
      dur_q      <= NOTE_LAST;
      half_q     <= half_reload(play_idx);
      tone_q     <= 1'b1;
      pend_vld_q <= 1'b0;
      spk        <= vol_gate;
      playing    <= 1'b1;
      note_idx   <= play_idx;
    end else begin
      case (state_q)
        IDLE: begin
          spk      <= 1'b0;
          playing  <= 1'b0;
          note_idx <= '0;
        end
        PLAY: begin
          // Any event reaching here is a rest; it cuts the note short.
          if (key_event || dur_q == '0) begin
            state_q  <= GAP;
            dur_q    <= GAP_LAST;
            tone_q   <= 1'b0;
            spk      <= 1'b0;
            playing  <= 1'b0;
            note_idx <= '0;
          end else begin
            dur_q <= dur_q - 1'b1;
            if (half_q == '0) begin
              half_q <= half_reload(note_q);
              tone_q <= ~tone_q;
              spk    <= ~tone_q & vol_gate;
            end else begin
              half_q <= half_q - 1'b1;
              spk    <= tone_q & vol_gate;
            end
          end
        end
        GAP: begin
          if (dur_q == '0) begin
            state_q    <= IDLE;
            pend_vld_q <= 1'b0;
          end else begin
            dur_q <= dur_q - 1'b1;
            if (key_event) begin
              pend_vld_q  <= ev_note.is_note;
              pend_note_q <= ev_note.idx;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          spk      <= 1'b0;
          playing  <= 1'b0;
          note_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kypd_tone_player.sv
// Bench for kypd_tone_player: time-stamp based reference model plus directed timing pins.
// Latency: n/a.
// Backpressure: n/a.
module tb_kypd_tone_player;

  localparam int DEB   = 4;
  localparam int NOTE  = 200;
  localparam int GAPC  = 20;
  localparam int SHIFT = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_code;
`ifdef KYPD_TONE_VOLUME_EN
  logic [1:0] vol;
`endif
  logic       spk;
  logic       playing;
  logic [2:0] note_idx;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  kypd_tone_player #(
    .DEBOUNCE_CYC(DEB),
    .NOTE_CYC    (NOTE),
    .GAP_CYC     (GAPC),
    .TONE_SHIFT  (SHIFT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_code(key_code),
`ifdef KYPD_TONE_VOLUME_EN
    .vol     (vol),
`endif
    .spk     (spk),
    .playing (playing),
    .note_idx(note_idx)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: remembers when the current note/gap began and
  // derives the outputs from elapsed time.
  // ------------------------------------------------------------------
  function automatic int half_cyc(input int idx);
    int b;
    case (idx)
      1: b = 191110;
      2: b = 170265;
      3: b = 151685;
      4: b = 143172;
      5: b = 127551;
      6: b = 113636;
      7: b = 101239;
      default: b = 95557;
    endcase
    return b >> SHIFT;
  endfunction

  int cyc = 0;
  int m_mode = 0;      // 0 idle, 1 play, 2 gap
  int m_t0 = 0;
  int m_note = 0;
  int m_pend = -1;
  int m_stable = 0;
  bit m_ev_next = 0;
  int hist[$];
  int exp_spk = 0, exp_play = 0, exp_idx = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      cyc = 0; m_mode = 0; m_t0 = 0; m_note = 0; m_pend = -1;
      m_stable = 0; m_ev_next = 0;
      hist.delete();
      hist.push_back(0);
    end else begin
      bit ev;
      int evc, idx;
      bit is_note, same;
      cyc++;
      ev  = m_ev_next;
      evc = m_stable;
      is_note = (evc >= 1) && (evc <= 8);
      idx = evc % 8;
      case (m_mode)
        0: if (ev && is_note) begin m_mode = 1; m_t0 = cyc; m_note = idx; end
        1: begin
          if (ev && is_note) begin m_t0 = cyc; m_note = idx; end
          else if (ev || (cyc - m_t0) >= NOTE) begin m_mode = 2; m_t0 = cyc; end
        end
        default: begin
          if (ev) m_pend = is_note ? idx : -1;
          if ((cyc - m_t0) >= GAPC) begin
            if (m_pend >= 0) begin m_mode = 1; m_t0 = cyc; m_note = m_pend; end
            else m_mode = 0;
            m_pend = -1;
          end
        end
      endcase
      // A code is accepted once DEB+1 consecutive samples agree.
      hist.push_back(int'(key_code));
      if (hist.size() > DEB + 1) void'(hist.pop_front());
      m_ev_next = 0;
      if (hist.size() == DEB + 1) begin
        same = 1;
        foreach (hist[i]) if (hist[i] != hist[0]) same = 0;
        if (same) begin
          if (hist[0] != m_stable) m_ev_next = 1;
          m_stable = hist[0];
        end
      end
    end
    exp_play = (m_mode == 1);
    exp_idx  = exp_play ? m_note : 0;
    exp_spk  = exp_play && ((((cyc - m_t0) / half_cyc(m_note)) % 2) == 0);
`ifdef KYPD_TONE_VOLUME_EN
    if (rst_n) exp_spk = exp_spk && ((cyc % 4) <= int'(vol));
`endif
  end

  // Compare DUT against the model on every falling edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("spk", spk, exp_spk);
      check("playing", playing, exp_play);
      check("note_idx", note_idx, exp_idx);
    end
  end

  function automatic logic sig(input int which);
    return (which == 0) ? playing : spk;
  endfunction

  task automatic wait_sig(input int which, input logic lvl, input int budget, input string name);
    for (int i = 0; i < budget && sig(which) !== lvl; i++) @(negedge clk);
    check(name, sig(which), lvl);
  endtask

  task automatic count_play(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      if (playing) hi++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int s, r, g, c, n;
    rst_n = 1'b1;
    key_code = 4'h0;
`ifdef KYPD_TONE_VOLUME_EN
    vol = 2'd3;
`endif
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("rst_spk", spk, 0);
    check("rst_playing", playing, 0);
    check("rst_note_idx", note_idx, 0);
    rst_n = 1'b1;

    // Code 0 after reset: nothing happens.
    count_play(30, n);
    check("idle_zero_code", n, 0);

    // 0 -> 1: rise 5 cycles after the first edge that sees the new code.
    key_code = 4'h1;
    s = cyc + 1;
    wait_sig(0, 1'b1, 20, "c4_rise");
    r = cyc;
    check("rise_latency", r - s, 5);
    wait_sig(1, 1'b0, 100, "c4_spk_fall");
    check("c4_half", cyc - r, 46);
    wait_sig(0, 1'b0, 300, "c4_end");
    check("note_len", cyc - r, 200);
    count_play(40, n);
    check("gap_then_idle", n, 0);

    // Short glitch: no event.
    key_code = 4'h0;
    repeat (10) @(negedge clk);
    key_code = 4'h1;
    repeat (3) @(negedge clk);
    key_code = 4'h0;
    count_play(20, n);
    check("glitch_no_play", n, 0);

    // Restart during PLAY with G4.
    key_code = 4'h1;
    wait_sig(0, 1'b1, 20, "restart_first");
    repeat (60) @(negedge clk);
    key_code = 4'h5;
    s = cyc + 1;
    for (int i = 0; i < 20 && note_idx != 3'd5; i++) @(negedge clk);
    c = cyc;
    check("restart_idx", note_idx, 5);
    check("restart_latency", c - s, 5);
    wait_sig(1, 1'b0, 60, "g4_spk_fall");
    check("g4_half", cyc - c, 31);
    wait_sig(0, 1'b0, 300, "g4_end");
    check("restart_len", cyc - c, 200);

    // Rest during PLAY -> GAP at once; note during GAP starts at GAP end.
    key_code = 4'h2;
    wait_sig(0, 1'b1, 60, "d4_rise");
    repeat (30) @(negedge clk);
    key_code = 4'h0;
    s = cyc + 1;
    wait_sig(0, 1'b0, 20, "rest_cut");
    g = cyc;
    check("rest_to_gap", g - s, 5);
    key_code = 4'h3;
    wait_sig(0, 1'b1, 40, "pending_rise");
    check("pending_start", cyc - g, 20);
    check("pending_note", note_idx, 3);

    // Asynchronous reset mid-note.
    repeat (10) @(negedge clk);
    wait_sig(1, 1'b1, 100, "pre_reset_spk");
    #2 rst_n = 1'b0;
    #1;
    check("async_spk", spk, 0);
    check("async_playing", playing, 0);
    check("async_note_idx", note_idx, 0);
    key_code = 4'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    count_play(30, n);
    check("idle_after_reset", n, 0);

    // Randomised key sequences, checked by the model every cycle.
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 2) == 0) key_code = 4'($urandom_range(0, 15));
      else key_code = 4'($urandom_range(1, 8));
`ifdef KYPD_TONE_VOLUME_EN
      vol = 2'($urandom_range(0, 3));
`endif
      repeat ($urandom_range(1, 80)) @(negedge clk);
    end
    key_code = 4'h0;
    repeat (300) @(negedge clk);

`ifdef KYPD_TONE_VOLUME_EN
    // vol=0: one high cycle in four during the high half-wave.
    vol = 2'd0;
    key_code = 4'h4;
    wait_sig(0, 1'b1, 20, "vol_rise");
    n = 0;
    repeat (8) begin
      if (spk) n++;
      @(negedge clk);
    end
    check("vol0_duty", n, 2);
    key_code = 4'h0;
    repeat (300) @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
